// File: rtl/seq_pattern_tx.sv
// Bit-serial pattern transmitter: shifts a PATTERN_W-bit word out MSB first, one bit per
// BIT_DIV+1 clocks, with a strobe in the last clock of each bit and optional back-to-back repeat.
module seq_pattern_tx #(
    parameter int                   PATTERN_W = 5,
    parameter logic [PATTERN_W-1:0] PATTERN   = 5'b11011,
    parameter int                   BIT_DIV   = 2499999,
    parameter int                   CNT_W     = 22
) (
    input  logic                 i_clk_in,
    input  logic                 i_clear,
    input  logic                 i_load,
    input  logic [PATTERN_W-1:0] i_pattern_in,
    input  logic                 i_start,
    input  logic                 i_repeat_en,
    output logic                 o_bit_out,
    output logic                 o_bit_pulse,
    output logic [2:0]           o_bit_idx,
    output logic                 o_busy,
    output logic                 o_done
);

    localparam logic [CNT_W-1:0] DIV_MAX     = CNT_W'(BIT_DIV);
    localparam logic [2:0]       LAST_IDX    = 3'(PATTERN_W - 1);
    localparam logic             FIRST_PULSE = (BIT_DIV == 0) ? 1'b1 : 1'b0;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    state_t               r_state;
    logic [PATTERN_W-1:0] r_shadow;
    logic [PATTERN_W-1:0] r_shreg;
    logic [CNT_W-1:0]     r_div_cnt;
    logic [2:0]           r_bit_idx;
    logic                 r_bit_pulse;
    logic                 r_busy;
    logic                 r_done;

    logic [PATTERN_W-1:0] w_start_pat;
    logic [CNT_W-1:0]     w_div_inc;
    logic                 w_period_end;
    logic                 w_next_pulse;
    logic                 w_last_bit;

    // A load in the start cycle wins, so the frame carries the freshly loaded word.
    assign w_start_pat  = i_load ? i_pattern_in : r_shadow;
    assign w_div_inc    = r_div_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    assign w_period_end = (r_div_cnt == DIV_MAX);
    assign w_next_pulse = (w_div_inc == DIV_MAX);
    assign w_last_bit   = (r_bit_idx == LAST_IDX);

    // Transmit FSM; the serial bit is the shift-register MSB, cleared whenever idle.
    always_ff @(posedge i_clk_in) begin
        if (i_clear) begin
            r_state     <= ST_IDLE;
            r_shadow    <= PATTERN;
            r_shreg     <= {PATTERN_W{1'b0}};
            r_div_cnt   <= {CNT_W{1'b0}};
            r_bit_idx   <= 3'd0;
            r_bit_pulse <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_load) begin
                        r_shadow <= i_pattern_in;
                    end
                    if (i_start) begin
                        r_state     <= ST_SEND;
                        r_shreg     <= w_start_pat;
                        r_div_cnt   <= {CNT_W{1'b0}};
                        r_bit_idx   <= 3'd0;
                        r_bit_pulse <= FIRST_PULSE;
                        r_busy      <= 1'b1;
                    end
                end
                ST_SEND: begin
                    if (w_period_end) begin
                        r_div_cnt <= {CNT_W{1'b0}};
                        if (w_last_bit) begin
                            if (i_repeat_en) begin
                                r_shreg     <= r_shadow;
                                r_bit_idx   <= 3'd0;
                                r_bit_pulse <= FIRST_PULSE;
                            end else begin
                                r_state     <= ST_IDLE;
                                r_shreg     <= {PATTERN_W{1'b0}};
                                r_bit_idx   <= 3'd0;
                                r_bit_pulse <= 1'b0;
                                r_busy      <= 1'b0;
                                r_done      <= 1'b1;
                            end
                        end else begin
                            r_shreg     <= {r_shreg[PATTERN_W-2:0], 1'b0};
                            r_bit_idx   <= r_bit_idx + 3'd1;
                            r_bit_pulse <= FIRST_PULSE;
                        end
                    end else begin
                        r_div_cnt   <= w_div_inc;
                        r_bit_pulse <= w_next_pulse;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_shreg     <= {PATTERN_W{1'b0}};
                    r_div_cnt   <= {CNT_W{1'b0}};
                    r_bit_idx   <= 3'd0;
                    r_bit_pulse <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign o_bit_out   = r_shreg[PATTERN_W-1];
    assign o_bit_pulse = r_bit_pulse;
    assign o_bit_idx   = r_bit_idx;
    assign o_busy      = r_busy;
    assign o_done      = r_done;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Directed bench for seq_pattern_tx: a cycle-by-cycle vector table for a BIT_DIV=3 instance
// plus a hand-written repeat sequence on a BIT_DIV=0 instance.
module tb_seq_pattern_tx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       a_clear, a_load, a_start, a_rep;
    logic [4:0] a_pin;
    logic       a_bit, a_pulse, a_busy, a_done;
    logic [2:0] a_idx;

    logic       b_clear, b_start, b_rep;
    logic       b_bit, b_pulse, b_busy, b_done;
    logic [2:0] b_idx;
    logic       b_load;
    logic [4:0] b_pin;

    seq_pattern_tx #(.PATTERN_W(5), .PATTERN(5'b11011), .BIT_DIV(3), .CNT_W(4)) u_dut_a (
        .i_clk_in(clk), .i_clear(a_clear), .i_load(a_load), .i_pattern_in(a_pin),
        .i_start(a_start), .i_repeat_en(a_rep), .o_bit_out(a_bit), .o_bit_pulse(a_pulse),
        .o_bit_idx(a_idx), .o_busy(a_busy), .o_done(a_done));

    seq_pattern_tx #(.PATTERN_W(5), .PATTERN(5'b11011), .BIT_DIV(0), .CNT_W(1)) u_dut_b (
        .i_clk_in(clk), .i_clear(b_clear), .i_load(b_load), .i_pattern_in(b_pin),
        .i_start(b_start), .i_repeat_en(b_rep), .o_bit_out(b_bit), .o_bit_pulse(b_pulse),
        .o_bit_idx(b_idx), .o_busy(b_busy), .o_done(b_done));

    typedef struct {
        logic       clr;
        logic       ld;
        logic       st;
        logic [4:0] pin;
        logic [6:0] exp;
        string      tag;
    } vec_t;

    vec_t vq[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic logic [6:0] pk(logic b, logic p, logic [2:0] i, logic bu, logic d);
        return {b, p, i, bu, d};
    endfunction

    function automatic void push(logic clr, logic ld, logic st, logic [4:0] pin,
                                 logic [6:0] exp, string tag);
        vec_t v;
        v.clr = clr; v.ld = ld; v.st = st; v.pin = pin; v.exp = exp; v.tag = tag;
        vq.push_back(v);
    endfunction

    // Frame of pattern pat started by row 1; bit k is held 4 cycles, strobe every 4th cycle.
    function automatic void add_frame(logic [4:0] pat, logic ld_first, int last_c, string tag);
        for (int c = 1; c <= last_c; c++) begin
            int idx;
            idx = (c - 1) / 4;
            push(1'b0, (c == 1) && ld_first, c == 1, pat,
                 pk(pat[4-idx], (c % 4) == 0, 3'(idx), 1'b1, 1'b0), tag);
        end
        if (last_c == 20) push(1'b0, 1'b0, 1'b0, pat, pk(1'b0, 1'b0, 3'd0, 1'b0, 1'b1), {tag, "_done"});
    endfunction

    task automatic check(string tag, int row, logic [6:0] act, logic [6:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s row %0d: got bit/pulse/idx/busy/done=%b/%b/%0d/%b/%b required %b/%b/%0d/%b/%b",
                     tag, row, act[6], act[5], act[4:2], act[1], act[0],
                     exp[6], exp[5], exp[4:2], exp[1], exp[0]);
        end
    endtask

    initial begin
        logic [4:0] p;
        int         s;
        a_clear = 1'b0; a_load = 1'b0; a_start = 1'b0; a_rep = 1'b0; a_pin = 5'd0;
        b_clear = 1'b0; b_start = 1'b0; b_rep = 1'b0; b_load = 1'b0; b_pin = 5'd0;

        push(1'b1, 1'b0, 1'b0, 5'd0, 7'd0, "reset");
        push(1'b1, 1'b0, 1'b0, 5'd0, 7'd0, "reset");
        add_frame(5'b11011, 1'b0, 20, "t1_default");
        push(1'b0, 1'b0, 1'b0, 5'd0, 7'd0, "t1_idle");
        push(1'b0, 1'b1, 1'b0, 5'b10110, 7'd0, "t2_load");
        add_frame(5'b10110, 1'b0, 20, "t2_loaded");
        push(1'b0, 1'b0, 1'b0, 5'd0, 7'd0, "t2_idle");
        s = vq.size();
        add_frame(5'b10110, 1'b0, 20, "t4_busy_ignore");
        foreach (vq[i]) begin
            if (i == s + 3 || i == s + 9 || i == s + 14 || i == s + 19) begin
                vq[i].st = 1'b1; vq[i].ld = 1'b1; vq[i].pin = 5'b00000;
            end
        end
        push(1'b0, 1'b0, 1'b0, 5'd0, 7'd0, "t4_idle");
        add_frame(5'b10110, 1'b0, 20, "t4_shadow_kept");
        push(1'b0, 1'b0, 1'b0, 5'd0, 7'd0, "t4_idle2");
        add_frame(5'b10110, 1'b0, 9, "t5_pre_abort");
        push(1'b1, 1'b0, 1'b0, 5'd0, 7'd0, "t5_abort");
        for (int i = 0; i < 3; i++) push(1'b0, 1'b0, 1'b0, 5'd0, 7'd0, "t5_no_done");
        add_frame(5'b11011, 1'b0, 20, "t5_fresh_default");
        push(1'b0, 1'b0, 1'b0, 5'd0, 7'd0, "t5_idle");
        add_frame(5'b01101, 1'b1, 20, "t6_load_start");
        add_frame(5'b01101, 1'b0, 20, "t6_restart_on_done");
        push(1'b0, 1'b0, 1'b0, 5'd0, 7'd0, "t6_idle");

        @(negedge clk);
        foreach (vq[i]) begin
            a_clear = vq[i].clr; a_load = vq[i].ld; a_start = vq[i].st; a_pin = vq[i].pin;
            @(posedge clk);
            @(negedge clk);
            check(vq[i].tag, i, pk(a_bit, a_pulse, a_idx, a_busy, a_done), vq[i].exp);
        end
        a_clear = 1'b0; a_load = 1'b0; a_start = 1'b0;

        // BIT_DIV=0 with repeat: 11011 11011 11011 then repeat drops before the third frame end.
        p = 5'b11011;
        b_clear = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("t3_reset", 0, pk(b_bit, b_pulse, b_idx, b_busy, b_done), 7'd0);
        b_clear = 1'b0;
        for (int c = 1; c <= 15; c++) begin
            int idx;
            b_start = (c == 1);
            b_rep   = (c <= 11);
            @(posedge clk);
            @(negedge clk);
            idx = (c - 1) % 5;
            check("t3_repeat_stream", c, pk(b_bit, b_pulse, b_idx, b_busy, b_done),
                  pk(p[4-idx], 1'b1, 3'(idx), 1'b1, 1'b0));
        end
        b_start = 1'b0;
        b_rep   = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("t3_done", 16, pk(b_bit, b_pulse, b_idx, b_busy, b_done), pk(1'b0, 1'b0, 3'd0, 1'b0, 1'b1));
        @(posedge clk);
        @(negedge clk);
        check("t3_idle", 17, pk(b_bit, b_pulse, b_idx, b_busy, b_done), 7'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
